reg_file_wb: RTL and testbench
==============================

# reg_file_wb

Eight-entry, 16-bit register file with write-back scoreboard for the 16-bit pipelined RISC core. It sits directly downstream of the write-back 3-to-8 destination decoder and consumes that decoder's one-hot write-enable vector. It provides two registered read ports with same-cycle write bypass to the decode stage. A per-register pending scoreboard drives the decode-stage RAW-hazard stall.

## Interface
- DATA_W, 16, register width
- NREG, 8, register count; fixed by the 3-bit address and 8-bit one-hot select
- clk  in  1  rising-edge clock, single domain
- rst  in  1  synchronous, active-high reset
- wr_sel  in  [0:7]  one-hot write select from write-back decoder; bit i = R[i]; all-zero = no write
- wr_data  in  DATA_W  write-back data
- rd_en_a, rd_en_b  in  1  source operand A/B used by instruction in decode
- rd_addr_a, rd_addr_b  in  3  source register addresses
- rd_data_a, rd_data_b  out  DATA_W  registered read data
- iss_valid  in  1  instruction with destination leaves decode this cycle
- iss_dest  in  3  its destination register
- stall  out  1  combinational RAW-hazard stall to decode
- pend  out  [0:7]  registered pending vector; bit i set = write to R[i] outstanding
- err_onehot  out  1  sticky flag: multi-hot wr_sel seen

## Operation
- Write: if wr_sel has exactly one bit i set, R[i] <= wr_data at clk edge. If all-zero, no write.
- Multi-hot wr_sel: no register is written, and pend is not cleared by it. err_onehot is set the next edge and held until rst.
- Read (each port independently): rd_data <= R[rd_addr] at every edge. If wr_sel selects the same register in that cycle, rd_data <= wr_data (write-first bypass). rd_en does not gate the read.
- Stall: stall = (rd_en_a & pend[rd_addr_a] & ~wr_sel[rd_addr_a]) | (same for B). A register written back this cycle does not stall, because the bypass delivers its value next cycle.
- Issue: a one-hot decode of iss_dest is OR'd into pend only when iss_valid & ~stall. iss_valid while stall is high is ignored.
- Clear: a legal one-hot wr_sel bit i clears pend[i].
- Same register set by issue and cleared by write-back in one cycle: set wins, so pend[i] = 1.
- Issue to a register that is already pending: it stays pending. Writes are not counted.
- All 8 registers are general purpose. R0 is writable.

## Timing
- Reset values: R[0..7] = 0, rd_data_a/b = 0, pend = 0, err_onehot = 0. stall follows its inputs and pend = 0.
- Reset mid-operation: everything is cleared at the edge where rst = 1. Writes and issues in that cycle are discarded.
- Read latency: 1 cycle from address to rd_data.
- Write-to-read visibility: a write at edge N is visible on rd_data after edge N when read in the same cycle (bypass), and from storage thereafter.
- pend updates at the edge after issue or write-back. stall reflects the current pend with no extra delay.
- Two ports reading the same register give identical data.

## Structure
- Shared core package: DATA_W, NREG, register-address width (3), and a onehot3to8 function. The function must match the decoder's [0:7] bit ordering.
- The scoreboard is one natural sub-module, reg_scoreboard. It holds pend, the set/clear priority, and the stall equation.
- The storage array, read registers and bypass stay in reg_file_wb.

## Test plan
- Reset then read all: rst 1 cycle, read R0..R7 on both ports -> all rd_data = 0x0000, pend = 0x00, err_onehot = 0.
- Write/read: wr_sel = 8'b0001_0000 (R3), wr_data = 0xBEEF; next cycle rd_addr_a = 3 -> rd_data_a = 0xBEEF. The same-cycle read of R3 also returns 0xBEEF (bypass).
- Hazard: iss_valid, iss_dest = 5 -> pend[5] = 1. Then rd_en_a, rd_addr_a = 5 -> stall = 1 and a concurrent issue is ignored. Then wr_sel = R5, wr_data = 0x1234 -> stall = 0 that cycle, rd_data_a = 0x1234 next, pend[5] = 0.
- Set-wins: pend[2] = 1; same cycle iss_valid, iss_dest = 2, and wr_sel = R2 -> pend[2] stays 1 and R2 is updated.
- Multi-hot: wr_sel = 8'b1100_0000, wr_data = 0xFFFF -> R0 and R1 unchanged, err_onehot = 1 until rst.
- Reset mid-operation: pend = 0x0F, regs nonzero, rst asserted together with a write -> all regs 0, pend 0, write discarded.

Source files
------------

// File: rtl/reg_file_wb_pkg.sv
// reg_file_wb_pkg: shared widths and select helpers for the register file
package reg_file_wb_pkg;
   localparam int DATA_W = 16;
   localparam int NREG = 8;
   localparam int AW = 3;
   function automatic logic [0:NREG-1] onehot3to8(input logic [AW-1:0] a);
      logic [0:NREG-1] r;
      r = '0;
      r[a] = 1'b1;
      return r;
   endfunction
   function automatic logic is_onehot(input logic [0:NREG-1] v);
      return (v != '0) && ((v & (v - NREG'(1))) == '0);
   endfunction
endpackage

// File: rtl/reg_file_wb_scoreboard.sv
// reg_scoreboard: per-register pending bits and decode RAW-hazard stall
module reg_scoreboard
   import reg_file_wb_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [0:NREG-1] wr_sel,
   input  logic            wr_ok,
   input  logic            rd_en_a,
   input  logic [AW-1:0]   rd_addr_a,
   input  logic            rd_en_b,
   input  logic [AW-1:0]   rd_addr_b,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_dest,
   output logic            stall,
   output logic [0:NREG-1] pend
);
   logic [0:NREG-1] set_v, clr_v;
   // a register written back this cycle is bypassed, so it never stalls
   always_comb begin
      stall = (rd_en_a & pend[rd_addr_a] & ~wr_sel[rd_addr_a]) |
              (rd_en_b & pend[rd_addr_b] & ~wr_sel[rd_addr_b]);
      set_v = (iss_valid && !stall) ? onehot3to8(iss_dest) : '0;
      clr_v = wr_ok ? wr_sel : '0;
   end
   // clear first, then set, so a same-cycle issue keeps the register pending
   always_ff @(posedge clk)
      pend <= rst ? '0 : (pend & ~clr_v) | set_v;
endmodule

// File: rtl/reg_file_wb.sv
// reg_file_wb: 8x16 register file, two bypassed read ports, pending scoreboard
module reg_file_wb
   import reg_file_wb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [0:NREG-1]   wr_sel,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en_a,
   input  logic              rd_en_b,
   input  logic [AW-1:0]     rd_addr_a,
   input  logic [AW-1:0]     rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              iss_valid,
   input  logic [AW-1:0]     iss_dest,
   output logic              stall,
   output logic [0:NREG-1]   pend,
   output logic              err_onehot
);
   logic [DATA_W-1:0] regs [NREG];
   logic wr_ok;
   assign wr_ok = is_onehot(wr_sel);
   // storage: only a legal one-hot select writes
   always_ff @(posedge clk)
      for (int i = 0; i < NREG; i++)
         if (rst) regs[i] <= '0;
         else if (wr_ok && wr_sel[i]) regs[i] <= wr_data;
   // read ports with write-first bypass of a legal write
   always_ff @(posedge clk)
      if (rst) begin
         rd_data_a <= '0;
         rd_data_b <= '0;
      end else begin
         rd_data_a <= (wr_ok && wr_sel[rd_addr_a]) ? wr_data : regs[rd_addr_a];
         rd_data_b <= (wr_ok && wr_sel[rd_addr_b]) ? wr_data : regs[rd_addr_b];
      end
   // sticky flag for a multi-hot write select
   always_ff @(posedge clk)
      if (rst) err_onehot <= 1'b0;
      else if (wr_sel != '0 && !wr_ok) err_onehot <= 1'b1;
   reg_scoreboard u_sb (
      .clk(clk), .rst(rst), .wr_sel(wr_sel), .wr_ok(wr_ok),
      .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
      .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
      .iss_valid(iss_valid), .iss_dest(iss_dest),
      .stall(stall), .pend(pend)
   );
endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: directed vector table plus randomized model check
module tb_reg_file_wb;
   import reg_file_wb_pkg::*;
   logic clk = 0, rst = 0;
   logic [0:7] wr_sel = '0;
   logic [15:0] wr_data = '0;
   logic rd_en_a = 0, rd_en_b = 0, iss_valid = 0;
   logic [2:0] rd_addr_a = '0, rd_addr_b = '0, iss_dest = '0;
   logic [15:0] rd_data_a, rd_data_b;
   logic stall, err_onehot;
   logic [0:7] pend;
   int nvec = 0, nfail = 0;

   reg_file_wb dut (
      .clk(clk), .rst(rst), .wr_sel(wr_sel), .wr_data(wr_data),
      .rd_en_a(rd_en_a), .rd_en_b(rd_en_b), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .iss_valid(iss_valid), .iss_dest(iss_dest),
      .stall(stall), .pend(pend), .err_onehot(err_onehot)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic rst; logic [0:7] wr_sel; logic [15:0] wr_data;
      logic ena; logic [2:0] aa; logic enb; logic [2:0] ab;
      logic iv; logic [2:0] id;
      logic e_stall; logic [15:0] e_rda, e_rdb; logic [0:7] e_pend; logic e_err;
   } vec_t;

   function automatic vec_t mk(input int r, ws, wd, ea, aa, eb, ab, iv, id, es, era, erb, ep, ee);
      vec_t v;
      v.rst = 1'(r); v.wr_sel = 8'(ws); v.wr_data = 16'(wd);
      v.ena = 1'(ea); v.aa = 3'(aa); v.enb = 1'(eb); v.ab = 3'(ab);
      v.iv = 1'(iv); v.id = 3'(id);
      v.e_stall = 1'(es); v.e_rda = 16'(era); v.e_rdb = 16'(erb); v.e_pend = 8'(ep); v.e_err = 1'(ee);
      return v;
   endfunction

   // behavioural reference: plain arrays updated from the written rules
   logic [15:0] m_regs [8];
   bit m_pend [8];
   bit m_err;
   logic [15:0] m_rda, m_rdb;

   function automatic bit model_stall(input vec_t v);
      return (v.ena && m_pend[v.aa] && !v.wr_sel[v.aa]) || (v.enb && m_pend[v.ab] && !v.wr_sel[v.ab]);
   endfunction

   function automatic logic [0:7] model_pend();
      logic [0:7] p;
      for (int i = 0; i < 8; i++) p[i] = m_pend[i];
      return p;
   endfunction

   task automatic model_edge(input vec_t v, input bit st);
      int n, w;
      n = 0; w = 0;
      for (int i = 0; i < 8; i++) if (v.wr_sel[i]) begin n++; w = i; end
      if (v.rst) begin
         for (int i = 0; i < 8; i++) begin m_regs[i] = 0; m_pend[i] = 0; end
         m_err = 0; m_rda = 0; m_rdb = 0;
      end else begin
         m_rda = (n == 1 && w == int'(v.aa)) ? v.wr_data : m_regs[v.aa];
         m_rdb = (n == 1 && w == int'(v.ab)) ? v.wr_data : m_regs[v.ab];
         if (n == 1) begin m_regs[w] = v.wr_data; m_pend[w] = 0; end
         if (n > 1) m_err = 1;
         if (v.iv && !st) m_pend[v.id] = 1;
      end
   endtask

   task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s @%0d: got %h expected %h", nm, k, got, exp);
      end
   endtask

   task automatic run(input vec_t v, input bit tbl, input int k);
      bit ms;
      logic gs;
      @(negedge clk);
      rst = v.rst; wr_sel = v.wr_sel; wr_data = v.wr_data;
      rd_en_a = v.ena; rd_addr_a = v.aa; rd_en_b = v.enb; rd_addr_b = v.ab;
      iss_valid = v.iv; iss_dest = v.id;
      #1;
      ms = model_stall(v);
      gs = stall;
      model_edge(v, ms);
      @(posedge clk);
      #1;
      chk("stall", k, 32'(gs), tbl ? 32'(v.e_stall) : 32'(ms));
      chk("rd_data_a", k, 32'(rd_data_a), tbl ? 32'(v.e_rda) : 32'(m_rda));
      chk("rd_data_b", k, 32'(rd_data_b), tbl ? 32'(v.e_rdb) : 32'(m_rdb));
      chk("pend", k, 32'(pend), tbl ? 32'(v.e_pend) : 32'(model_pend()));
      chk("err_onehot", k, 32'(err_onehot), tbl ? 32'(v.e_err) : 32'(m_err));
   endtask

   vec_t tbl[$];

   initial begin
      vec_t v;
      logic [0:7] ws;
      int idx;
      tbl.push_back(mk(1, 0, 0, 0,0, 0,0, 0,0, 0, 0,0, 0, 0));
      for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 0, 0, 1,i, 1,7-i, 0,0, 0, 0,0, 0, 0));
      tbl.push_back(mk(0, 8'b0001_0000, 16'hBEEF, 1,3, 1,3, 0,0, 0, 16'hBEEF,16'hBEEF, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1,3, 1,0, 0,0, 0, 16'hBEEF,0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0,0, 0,0, 1,5, 0, 0,0, 8'b0000_0100, 0));
      tbl.push_back(mk(0, 0, 0, 1,5, 0,0, 1,6, 1, 0,0, 8'b0000_0100, 0));
      tbl.push_back(mk(0, 8'b0000_0100, 16'h1234, 1,5, 0,0, 0,0, 0, 16'h1234,0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1,5, 1,5, 0,0, 0, 16'h1234,16'h1234, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0,0, 0,0, 1,2, 0, 0,0, 8'b0010_0000, 0));
      tbl.push_back(mk(0, 8'b0010_0000, 16'hA5A5, 1,2, 0,3, 1,2, 0, 16'hA5A5,16'hBEEF, 8'b0010_0000, 0));
      tbl.push_back(mk(0, 8'b0010_0000, 16'h0002, 1,2, 0,0, 0,0, 0, 16'h0002,0, 0, 0));
      tbl.push_back(mk(0, 8'b1100_0000, 16'hFFFF, 0,0, 0,1, 0,0, 0, 0,0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0,0, 0,1, 0,0, 0, 0,0, 0, 1));
      tbl.push_back(mk(0, 8'b1000_0000, 16'h1111, 0,0, 0,1, 1,4, 0, 16'h1111,0, 8'b0000_1000, 1));
      tbl.push_back(mk(0, 8'b0100_0000, 16'h2222, 0,0, 0,1, 1,5, 0, 16'h1111,16'h2222, 8'b0000_1100, 1));
      tbl.push_back(mk(0, 0, 0, 0,0, 0,1, 1,6, 0, 16'h1111,16'h2222, 8'b0000_1110, 1));
      tbl.push_back(mk(0, 0, 0, 0,0, 0,1, 1,7, 0, 16'h1111,16'h2222, 8'b0000_1111, 1));
      tbl.push_back(mk(0, 0, 0, 1,6, 1,7, 0,0, 1, 0,0, 8'b0000_1111, 1));
      tbl.push_back(mk(1, 8'b1000_0000, 16'h9999, 1,0, 0,1, 1,3, 0, 0,0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1,0, 1,1, 0,0, 0, 0,0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1,3, 1,5, 0,0, 0, 0,0, 0, 0));
      for (int i = 0; i < 8; i++) begin m_regs[i] = 0; m_pend[i] = 0; end
      m_err = 0; m_rda = 0; m_rdb = 0;
      foreach (tbl[k]) run(tbl[k], 1, k);
      for (int k = 0; k < 500; k++) begin
         ws = '0;
         if ($urandom_range(0, 2) != 0) begin
            idx = $urandom_range(0, 7);
            ws[idx] = 1'b1;
         end
         v = mk($urandom_range(0, 49) == 0, ws, $urandom, $urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                0, 0, 0, 0, 0);
         run(v, 0, 1000 + k);
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
